vrf_wb_arbiter: RTL and testbench

Per-lane write-back arbiter that shares the single VRF write port between all write-back sources: the load unit (WB_VLU) and the ALU wrapper (WB_VALU). Each cycle it picks one pending source, grants it and latches its beat into a one-entry output register driving the VRF write port. Each completed write is reported with its instruction id to the hazard/commit logic. It sits between the VFU result buses and the `vrf_accesser` write path inside `lane`.

---
 rtl/core_pkg.sv | 26 ++
 rtl/rr_picker.sv | 32 +++
 rtl/vrf_wb_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_vrf_wb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared lane types: VRF beat fields, write-back source indices and the
// registered write-back beat record used by vrf_wb_arbiter.
package core_pkg;

    localparam int unsigned VrfDataWidth = 64;
    localparam int unsigned VrfAddrWidth = 10;
    localparam int unsigned InsnIdWidth  = 3;

    typedef logic [VrfDataWidth-1:0]   vrf_data_t;
    typedef logic [VrfDataWidth/8-1:0] vrf_strb_t;
    typedef logic [VrfAddrWidth-1:0]   vrf_addr_t;
    typedef logic [InsnIdWidth-1:0]    insn_id_t;

    // Write-back sources sharing the VRF write port.
    localparam int unsigned NrWriteBackVFU = 2;
    localparam int unsigned WB_VLU         = 0;
    localparam int unsigned WB_VALU        = 1;

    typedef struct packed {
        vrf_data_t wdata;
        vrf_strb_t wstrb;
        vrf_addr_t addr;
        insn_id_t  id;
    } wb_beat_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-one search: starting at ptr_i and wrapping
// upward, returns the first set request as one-hot and as an index.
module rr_picker #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    onehot_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [IdxW-1:0] cand;

    // Scan from the pointer with wrap; the first pending request wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IdxW'((32'(ptr_i) + off) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Per-lane write-back arbiter: picks one write-back source per cycle and
// latches its beat into a one-entry register driving the VRF write port.
// Optional feature macro: RVV_WB_LOAD_PRIO_EN (load strict priority with
// aging of the remaining requesters). Default build is pure round-robin.
module vrf_wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned NrReq    = NrWriteBackVFU,
    parameter int unsigned MaxStall = 4,
    localparam int unsigned IdxW    = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NrReq-1:0]        req_valid_i,
    input  vrf_data_t [NrReq-1:0]   req_wdata_i,
    input  vrf_strb_t [NrReq-1:0]   req_wstrb_i,
    input  vrf_addr_t [NrReq-1:0]   req_addr_i,
    input  insn_id_t  [NrReq-1:0]   req_id_i,
    output logic [NrReq-1:0]        req_gnt_o,
    output logic                    vrf_wvalid_o,
    input  logic                    vrf_wready_i,
    output vrf_data_t               vrf_wdata_o,
    output vrf_strb_t               vrf_wstrb_o,
    output vrf_addr_t               vrf_addr_o,
    output insn_id_t                vrf_id_o,
    output logic                    wb_done_o,
    output insn_id_t                wb_done_id_o
);

    if (MaxStall < 1) begin : g_bad_maxstall
        $error("vrf_wb_arbiter: MaxStall must be at least 1");
    end

`ifdef RVV_WB_LOAD_PRIO_EN
    // The round-robin ring covers requesters 1..NrReq-1 only.
    localparam int unsigned RrN = NrReq - 1;
`else
    localparam int unsigned RrN = NrReq;
`endif
    localparam int unsigned RrW = (RrN > 1) ? $clog2(RrN) : 1;

    logic [RrW-1:0]   rr_q, rr_d;
    wb_beat_t         beat_q, beat_d;
    logic             wvalid_q, wvalid_d;

    logic             load_en;
    logic             grant;
    logic [NrReq-1:0] win_oh;
    logic [IdxW-1:0]  win_idx;
    logic             win_valid;

    logic [RrN-1:0]   pick_req, pick_oh;
    logic [RrW-1:0]   pick_idx;
    logic             pick_valid;

    wb_beat_t         win_beat;

    assign load_en = !wvalid_q || vrf_wready_i;

    rr_picker #(
        .N (RrN)
    ) u_rr_picker (
        .req_i    (pick_req),
        .ptr_i    (rr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

`ifdef RVV_WB_LOAD_PRIO_EN
    localparam int unsigned CntW = $clog2(MaxStall + 1);

    logic [CntW-1:0] stall_q [RrN];
    logic [CntW-1:0] stall_d [RrN];
    logic [RrN-1:0]  aged;

    // A requester is aged once its stall counter has saturated.
    always_comb begin
        for (int unsigned j = 0; j < RrN; j++) begin
            aged[j] = req_valid_i[j+1] && (stall_q[j] == CntW'(MaxStall));
        end
    end

    // Aged requesters compete among themselves first; otherwise the
    // picker sees all pending non-load requesters.
    assign pick_req = (|aged) ? aged : req_valid_i[NrReq-1:1];

    // Aged > load > round-robin among the rest; picker index is offset by one.
    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        if (|aged || (!req_valid_i[0] && pick_valid)) begin
            win_valid = 1'b1;
            win_idx   = IdxW'(pick_idx) + IdxW'(1);
            win_oh    = {pick_oh, 1'b0};
        end else if (req_valid_i[0]) begin
            win_valid = 1'b1;
            win_idx   = '0;
            win_oh    = NrReq'(1);
        end
    end

    // Pointer only advances on grants to the round-robin ring.
    always_comb begin
        rr_d = rr_q;
        if (grant && (win_idx != '0)) begin
            rr_d = (pick_idx == RrW'(RrN - 1)) ? '0 : pick_idx + RrW'(1);
        end
    end

    // Stall counters: count lost opportunities, clear on grant or idle.
    always_comb begin
        for (int unsigned j = 0; j < RrN; j++) begin
            stall_d[j] = stall_q[j];
            if (!req_valid_i[j+1] || req_gnt_o[j+1]) begin
                stall_d[j] = '0;
            end else if (load_en && (stall_q[j] != CntW'(MaxStall))) begin
                stall_d[j] = stall_q[j] + CntW'(1);
            end
        end
    end

    // Stall counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned j = 0; j < RrN; j++) begin
                stall_q[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < RrN; j++) begin
                stall_q[j] <= stall_d[j];
            end
        end
    end
`else
    assign pick_req = req_valid_i;

    // Pure round-robin: the picker result is the winner.
    always_comb begin
        win_oh    = pick_oh;
        win_idx   = IdxW'(pick_idx);
        win_valid = pick_valid;
    end

    // Pointer moves to one past the granted index, wrapping.
    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = (pick_idx == RrW'(RrN - 1)) ? '0 : pick_idx + RrW'(1);
        end
    end
`endif

    assign grant     = win_valid && load_en && rst_ni;
    assign req_gnt_o = grant ? win_oh : '0;

    assign win_beat.wdata = req_wdata_i[win_idx];
    assign win_beat.wstrb = req_wstrb_i[win_idx];
    assign win_beat.addr  = req_addr_i[win_idx];
    assign win_beat.id    = req_id_i[win_idx];

    // Output register: load the winner, or empty on a drain without a grant.
    always_comb begin
        beat_d   = beat_q;
        wvalid_d = wvalid_q;
        if (load_en) begin
            wvalid_d = grant;
            if (grant) begin
                beat_d = win_beat;
            end
        end
    end

    // Beat register and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wvalid_q <= 1'b0;
            beat_q   <= '0;
            rr_q     <= '0;
        end else begin
            wvalid_q <= wvalid_d;
            beat_q   <= beat_d;
            rr_q     <= rr_d;
        end
    end

    assign vrf_wvalid_o = wvalid_q;
    assign vrf_wdata_o  = beat_q.wdata;
    assign vrf_wstrb_o  = beat_q.wstrb;
    assign vrf_addr_o   = beat_q.addr;
    assign vrf_id_o     = beat_q.id;

    assign wb_done_o    = wvalid_q && vrf_wready_i;
    assign wb_done_id_o = beat_q.id;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Self-checking bench for vrf_wb_arbiter: reset behaviour, a directed vector
// table, asynchronous reset mid-transfer and randomized traffic against a
// cycle-level reference model.
module tb_vrf_wb_arbiter;
    import core_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned MS = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid_i;
    vrf_data_t [N-1:0]   req_wdata_i;
    vrf_strb_t [N-1:0]   req_wstrb_i;
    vrf_addr_t [N-1:0]   req_addr_i;
    insn_id_t  [N-1:0]   req_id_i;
    logic [N-1:0]        req_gnt_o;
    logic                vrf_wvalid_o;
    logic                vrf_wready_i;
    vrf_data_t           vrf_wdata_o;
    vrf_strb_t           vrf_wstrb_o;
    vrf_addr_t           vrf_addr_o;
    insn_id_t            vrf_id_o;
    logic                wb_done_o;
    insn_id_t            wb_done_id_o;

    always #5 clk = ~clk;

    vrf_wb_arbiter #(
        .NrReq    (N),
        .MaxStall (MS)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid_i),
        .req_wdata_i  (req_wdata_i),
        .req_wstrb_i  (req_wstrb_i),
        .req_addr_i   (req_addr_i),
        .req_id_i     (req_id_i),
        .req_gnt_o    (req_gnt_o),
        .vrf_wvalid_o (vrf_wvalid_o),
        .vrf_wready_i (vrf_wready_i),
        .vrf_wdata_o  (vrf_wdata_o),
        .vrf_wstrb_o  (vrf_wstrb_o),
        .vrf_addr_o   (vrf_addr_o),
        .vrf_id_o     (vrf_id_o),
        .wb_done_o    (wb_done_o),
        .wb_done_id_o (wb_done_id_o)
    );

    int errors = 0;
    int checks = 0;

    // Requester side: each source holds one pending beat until granted.
    bit       pend [N];
    wb_beat_t rb   [N];

    // Reference model state.
    bit       m_v;
    wb_beat_t m_b;
    int       m_rr;
    int       m_stall [N];

    logic [N-1:0] last_gnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit rdy);
        for (int i = 0; i < N; i++) begin
            req_valid_i[i] = pend[i];
            req_wdata_i[i] = rb[i].wdata;
            req_wstrb_i[i] = rb[i].wstrb;
            req_addr_i[i]  = rb[i].addr;
            req_id_i[i]    = rb[i].id;
        end
        vrf_wready_i = rdy;
    endtask

    task automatic model_reset();
        m_v  = 1'b0;
        m_b  = '0;
        m_rr = 0;
        for (int i = 0; i < N; i++) m_stall[i] = 0;
    endtask

    // Winner by the arbitration rules, -1 if nobody is pending.
    function automatic int model_winner();
`ifdef RVV_WB_LOAD_PRIO_EN
        for (int k = 0; k < N - 1; k++) begin
            int j = 1 + (m_rr + k) % (N - 1);
            if (pend[j] && m_stall[j] == MS) return j;
        end
        if (pend[0]) return 0;
        for (int k = 0; k < N - 1; k++) begin
            int j = 1 + (m_rr + k) % (N - 1);
            if (pend[j]) return j;
        end
        return -1;
`else
        for (int k = 0; k < N; k++) begin
            int j = (m_rr + k) % N;
            if (pend[j]) return j;
        end
        return -1;
`endif
    endfunction

    // One cycle against the model; entered and left just after a negedge.
    task automatic step(input bit rdy);
        bit           le;
        int           w;
        logic [N-1:0] eg;
        apply(rdy);
        #1;
        le = !m_v || rdy;
        w  = model_winner();
        eg = '0;
        if (le && w >= 0) eg[w] = 1'b1;
        last_gnt = req_gnt_o;
        chk("gnt", 64'(req_gnt_o), 64'(eg));
        chk("wvalid", 64'(vrf_wvalid_o), 64'(m_v));
        if (m_v) begin
            chk("wdata", 64'(vrf_wdata_o), 64'(m_b.wdata));
            chk("wstrb", 64'(vrf_wstrb_o), 64'(m_b.wstrb));
            chk("addr", 64'(vrf_addr_o), 64'(m_b.addr));
            chk("id", 64'(vrf_id_o), 64'(m_b.id));
        end
        chk("done", 64'(wb_done_o), 64'(m_v && rdy));
        if (m_v && rdy) chk("done_id", 64'(wb_done_id_o), 64'(m_b.id));
        for (int j = 1; j < N; j++) begin
            if (!pend[j] || eg[j]) m_stall[j] = 0;
            else if (le && m_stall[j] < MS) m_stall[j]++;
        end
        if (le && w >= 0) begin
            m_b     = rb[w];
            m_v     = 1'b1;
            pend[w] = 1'b0;
`ifdef RVV_WB_LOAD_PRIO_EN
            if (w != 0) m_rr = w % (N - 1);
`else
            m_rr = (w + 1) % N;
`endif
        end else if (le) begin
            m_v = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] valid;
        logic       rdy;
        logic [1:0] gnt;
        logic       wv;
        logic       done;
        insn_id_t   id;
    } vec_t;

    vec_t vecs [12];

    task automatic fixed_beats();
        rb[0] = '{wdata: 64'hA0A0_0000_0000_00A0, wstrb: 8'hFF, addr: 10'h010, id: 3'd2};
        rb[1] = '{wdata: 64'hB1B1_0000_0000_00B1, wstrb: 8'h0F, addr: 10'h021, id: 3'd5};
    endtask

    task automatic new_beat(input int i);
        rb[i].wdata = {$urandom, $urandom};
        rb[i].wstrb = vrf_strb_t'($urandom);
        rb[i].addr  = vrf_addr_t'($urandom);
        rb[i].id    = insn_id_t'($urandom);
        pend[i]     = 1'b1;
    endtask

    initial begin
        // valid, rdy, gnt, wvalid, done, id of the registered beat
        vecs[0]  = '{2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 3'd2};
        vecs[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 3'd5};
        vecs[3]  = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2};
        vecs[4]  = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2};
        vecs[5]  = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2};
        vecs[6]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 3'd2};
        vecs[7]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 3'd5};
        vecs[8]  = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0};
        vecs[9]  = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 3'd5};
        vecs[10] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 3'd2};
        vecs[11] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0};

        // Reset held with both requesters pending.
        rst_n = 1'b0;
        fixed_beats();
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        apply(1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("rst_gnt", 64'(req_gnt_o), 64'd0);
            chk("rst_wvalid", 64'(vrf_wvalid_o), 64'd0);
            chk("rst_id", 64'(vrf_id_o), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

`ifndef RVV_WB_LOAD_PRIO_EN
        // Directed table: alternation, stall, drain+load, wrap.
        for (int v = 0; v < 12; v++) begin
            pend[0] = vecs[v].valid[0];
            pend[1] = vecs[v].valid[1];
            apply(vecs[v].rdy);
            #1;
            chk($sformatf("vec%0d_gnt", v), 64'(req_gnt_o), 64'(vecs[v].gnt));
            chk($sformatf("vec%0d_wvalid", v), 64'(vrf_wvalid_o), 64'(vecs[v].wv));
            chk($sformatf("vec%0d_done", v), 64'(wb_done_o), 64'(vecs[v].done));
            if (vecs[v].wv) begin
                chk($sformatf("vec%0d_id", v), 64'(vrf_id_o), 64'(vecs[v].id));
                chk($sformatf("vec%0d_addr", v), 64'(vrf_addr_o),
                    (vecs[v].id == 3'd2) ? 64'h010 : 64'h021);
            end
            if (vecs[v].done)
                chk($sformatf("vec%0d_done_id", v), 64'(wb_done_id_o), 64'(vecs[v].id));
            @(posedge clk);
            @(negedge clk);
        end
`else
        // Load pending every cycle; the ALU ages in after MaxStall losses.
        model_reset();
        pend[0] = 1'b1;
        pend[1] = 1'b0;
        step(1'b1);
        pend[0] = 1'b1;
        step(1'b1);
        new_beat(1);
        for (int k = 0; k < 7; k++) begin
            pend[0] = 1'b1;
            if (k > 4) pend[1] = 1'b0;
            step(1'b1);
            chk($sformatf("aged_k%0d_alu", k), 64'(last_gnt[1]), 64'(k == 4));
            chk($sformatf("aged_k%0d_load", k), 64'(last_gnt[0]), 64'(k != 4));
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        step(1'b1);
        step(1'b1);
`endif

        // Fill the register and hold it, then reset asynchronously.
        fixed_beats();
        pend[0] = 1'b1;
        pend[1] = 1'b0;
        apply(1'b0);
        @(posedge clk);
        @(negedge clk);
        pend[0] = 1'b0;
        apply(1'b1);
        #1;
        chk("pre_rst_wvalid", 64'(vrf_wvalid_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wvalid", 64'(vrf_wvalid_o), 64'd0);
        chk("async_rst_done", 64'(wb_done_o), 64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_hold_done", 64'(wb_done_o), 64'd0);
            chk("rst_hold_wvalid", 64'(vrf_wvalid_o), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("post_rst_done", 64'(wb_done_o), 64'd0);
        @(posedge clk);
        @(negedge clk);

        // Randomized traffic against the reference model.
        model_reset();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && (($urandom % 4) < ((i == 0) ? 3 : 2))) new_beat(i);
            end
            step(($urandom % 4) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
